// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared constants for the memory-mapped UART peripheral.
//   - register indices (DATA/STATUS/CTRL/DIV)
//   - STATUS and CTRL bit positions
//   - TX/RX FSM state encodings
//   - oversample ratio (16 ticks per bit) and mid-bit tick (7)
package mmio_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int unsigned ST_RX_EMPTY  = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_RX_FULL   = 2;
  localparam int unsigned ST_TX_IDLE   = 3;
  localparam int unsigned ST_RX_OVR    = 4;
  localparam int unsigned ST_FRAME_ERR = 5;
  localparam int unsigned ST_PAR_ERR   = 6;
  localparam int unsigned ST_TX_OVF    = 7;

  localparam int unsigned CT_IRQ_RX_EN = 0;
  localparam int unsigned CT_IRQ_TX_EN = 1;
  localparam int unsigned CT_PAR_EN    = 2;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  BIT_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  MID_TICK   = 4'd7;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, depth 2**AW, show-ahead read data.
// Ports:
//   clk, rst (async, active-low)
//   push/wdata : write side; ignored when full unless a pop happens the same cycle
//   pop/rdata  : read side; rdata is the head entry, pop ignored when empty
//   empty/full : derived from an occupancy count
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_periph.sv
// mmio_uart_periph: memory-mapped UART with TX/RX FIFOs, programmable baud
// divisor, sticky error flags and a level interrupt.
// Optional even parity is compiled in with `define MMIO_UART_PARITY_EN.
// Ports:
//   clk, rst (async, active-low)
//   sel, rd, wr : MMIO strobes (level); one access per rising edge of rd&sel / wr&sel
//   addr        : register index (0 DATA, 1 STATUS, 2 CTRL, 3 DIV)
//   data_in     : write data
//   data_out    : registered read data, held until the next read access
//   rx, tx      : serial pins (rx asynchronous, synchronised internally)
//   irq         : registered level interrupt
module mmio_uart_periph #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 19200,
  parameter int FIFO_AW  = 4,
  parameter int DBIT     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  import mmio_uart_pkg::*;

  localparam int         DIV_RST   = CLK_FREQ / (16 * BAUD) - 1;
  localparam logic [7:0] DIV_RST_V = 8'(DIV_RST);
  localparam logic [2:0] DBIT_LAST = 3'(DBIT - 1);

  // ---------------- access qualification ----------------
  logic rd_q, wr_q, rd_acc, wr_acc;

  assign rd_acc = rd & sel & ~rd_q;
  assign wr_acc = wr & sel & ~wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd & sel;
      wr_q <= wr & sel;
    end
  end

  // ---------------- registers ----------------
  logic [2:0] ctrl_q;
  logic [7:0] div_q;
  logic       par_en;

`ifdef MMIO_UART_PARITY_EN
  assign par_en = ctrl_q[CT_PAR_EN];
`else
  assign par_en = 1'b0;
`endif

  // ---------------- oversample tick ----------------
  // The divisor is only sampled at wrap, so a DIV write never shortens the
  // tick that is in progress.
  logic [7:0] tick_cnt;
  logic       tick;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= DIV_RST_V;
    else if (tick) tick_cnt <= div_q;
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // ---------------- FIFOs ----------------
  logic            tx_push, tx_pop, txf_empty, txf_full;
  logic            rx_push, rx_pop, rxf_empty, rxf_full;
  logic [DBIT-1:0] txf_rdata, rxf_rdata, rx_shift;

  sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (data_in[DBIT-1:0]),
    .pop   (tx_pop),
    .rdata (txf_rdata),
    .empty (txf_empty),
    .full  (txf_full)
  );

  sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_shift),
    .pop   (rx_pop),
    .rdata (rxf_rdata),
    .empty (rxf_empty),
    .full  (rxf_full)
  );

  assign tx_push = wr_acc & (addr == REG_DATA);
  assign rx_pop  = rd_acc & (addr == REG_DATA) & ~rxf_empty;

  // ---------------- TX FSM ----------------
  tx_state_t       tx_state;
  logic [3:0]      tx_tcnt;
  logic [2:0]      tx_bit;
  logic [DBIT-1:0] tx_shift;
  logic            tx_par, tx_bit_end, tx_idle;

  assign tx_bit_end = tick & (tx_tcnt == BIT_LAST);
  // Popping straight out of STOP keeps consecutive frames gap-free.
  assign tx_pop  = ~txf_empty & ((tx_state == TX_IDLE) |
                                 ((tx_state == TX_STOP) & tx_bit_end));
  assign tx_idle = txf_empty & (tx_state == TX_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      if (tick) tx_tcnt <= tx_tcnt + 1'b1;
      if (tx_pop) begin
        tx_state <= TX_START;
        tx       <= 1'b0;
        tx_tcnt  <= '0;
        tx_shift <= txf_rdata;
        tx_par   <= ^txf_rdata;
      end else begin
        case (tx_state)
          TX_IDLE: begin
            tx      <= 1'b1;
            tx_tcnt <= '0;
          end
          TX_START: if (tx_bit_end) begin
            tx       <= tx_shift[0];
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: if (tx_bit_end) begin
            if (tx_bit == DBIT_LAST) begin
              if (par_en) begin
                tx       <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx       <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx       <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end
          TX_PARITY: if (tx_bit_end) begin
            tx       <= 1'b1;
            tx_state <= TX_STOP;
          end
          TX_STOP: if (tx_bit_end) tx_state <= TX_IDLE;
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- RX path ----------------
  logic       rx_s1, rx_s;
  rx_state_t  rx_state;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bit;
  logic       rx_bad, rx_bit_end;
  logic       frame_set, par_set, ovr_set, ovf_set, status_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
    end
  end

  assign rx_bit_end = tick & (rx_tcnt == BIT_LAST);
  assign rx_push    = (rx_state == RX_STOP) & rx_bit_end & rx_s & ~rx_bad;
  assign frame_set  = (rx_state == RX_STOP) & rx_bit_end & ~rx_s;
  assign par_set    = (rx_state == RX_PARITY) & rx_bit_end & (rx_s != ^rx_shift);
  assign ovr_set    = rx_push & rxf_full & ~rx_pop;
  assign ovf_set    = tx_push & txf_full & ~tx_pop;
  assign status_clr = rd_acc & (addr == REG_STATUS);

  // After the START check the counter is restarted, so every later sample
  // lands 16 ticks after the previous one, i.e. at mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_bad   <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_tcnt <= '0;
          if (!rx_s) rx_state <= RX_START;
        end
        RX_START: if (tick) begin
          if (rx_tcnt == MID_TICK) begin
            rx_tcnt <= '0;
            rx_bit  <= '0;
            rx_bad  <= 1'b0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt <= rx_tcnt + 1'b1;
          end
        end
        RX_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 1'b1;
          if (rx_bit_end) begin
            rx_shift <= {rx_s, rx_shift[DBIT-1:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == DBIT_LAST) rx_state <= par_en ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: if (tick) begin
          rx_tcnt <= rx_tcnt + 1'b1;
          if (rx_bit_end) begin
            if (par_set) rx_bad <= 1'b1;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_tcnt <= rx_tcnt + 1'b1;
          if (rx_bit_end) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- sticky flags, register access, irq ----------------
  logic       rx_ovr_q, frame_err_q, par_err_q, tx_ovf_q;
  logic [7:0] status;

  always_comb begin
    status               = '0;
    status[ST_RX_EMPTY]  = rxf_empty;
    status[ST_TX_FULL]   = txf_full;
    status[ST_RX_FULL]   = rxf_full;
    status[ST_TX_IDLE]   = tx_idle;
    status[ST_RX_OVR]    = rx_ovr_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_PAR_ERR]   = par_err_q;
    status[ST_TX_OVF]    = tx_ovf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
      data_out    <= '0;
      ctrl_q      <= '0;
      div_q       <= DIV_RST_V;
      irq         <= 1'b0;
    end else begin
      // A flag event coinciding with a STATUS read survives the clear.
      rx_ovr_q    <= (rx_ovr_q    & ~status_clr) | ovr_set;
      frame_err_q <= (frame_err_q & ~status_clr) | frame_set;
      par_err_q   <= (par_err_q   & ~status_clr) | par_set;
      tx_ovf_q    <= (tx_ovf_q    & ~status_clr) | ovf_set;

      if (rd_acc) begin
        case (addr)
          REG_DATA:   data_out <= rxf_empty ? 8'h00 : 8'(rxf_rdata);
          REG_STATUS: data_out <= status;
          REG_CTRL:   data_out <= {5'b0, ctrl_q};
          default:    data_out <= div_q;
        endcase
      end

      if (wr_acc) begin
        case (addr)
          REG_CTRL: begin
            ctrl_q[CT_IRQ_RX_EN] <= data_in[CT_IRQ_RX_EN];
            ctrl_q[CT_IRQ_TX_EN] <= data_in[CT_IRQ_TX_EN];
`ifdef MMIO_UART_PARITY_EN
            ctrl_q[CT_PAR_EN]    <= data_in[CT_PAR_EN];
`else
            ctrl_q[CT_PAR_EN]    <= 1'b0;
`endif
          end
          REG_DIV: div_q <= data_in;
          default: ;
        endcase
      end

      irq <= (ctrl_q[CT_IRQ_RX_EN] & ~rxf_empty) | (ctrl_q[CT_IRQ_TX_EN] & tx_idle);
    end
  end

endmodule

// File: tb/tb_mmio_uart_periph.sv
module tb_mmio_uart_periph;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       tx, irq;
  logic       loop = 1'b0, rx_drv = 1'b1;
  logic       rx_line;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic wave [720];

  assign rx_line = loop ? tx : rx_drv;

  mmio_uart_periph #(.CLK_FREQ(50000000), .BAUD(19200), .FIFO_AW(4), .DBIT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rx       (rx_line),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int unsigned hold);
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = a; data_in = d;
    repeat (hold) @(negedge clk);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; rd = 1'b0;
    d = data_out;
  endtask

  // Drive one rx frame with 64-clock bits (DIV=3); a low stop bit is held
  // only past its mid-bit sample so the receiver's restart reads as a glitch.
  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (64) @(negedge clk);
    end
    rx_drv = stop;
    repeat (stop ? 64 : 48) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_out !== 8'h00 || tx !== 1'b1 || irq !== 1'b0)
      $display("FAIL reset_outputs: data_out=%h tx=%b irq=%b, required 00/1/0", data_out, tx, irq);
    else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h09) $display("FAIL reset_status: got %h, required 09", d); else n_pass++;
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 8'hA1) $display("FAIL reset_div: got %h, required a1", d); else n_pass++;
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 8'h00) $display("FAIL reset_ctrl: got %h, required 00", d); else n_pass++;
  endtask

  task automatic test_tx_frame();
    logic [7:0] d;
    logic [9:0] exp;
    int t, r, f, lows;
    bus_write(2'd3, 8'h03, 1);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 8'h03) $display("FAIL div_write: got %h, required 03", d); else n_pass++;
    repeat (200) @(negedge clk);  // let the old divisor wrap
    bus_write(2'd0, 8'hA5, 10);
    t = 0;
    while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    n_checks++;
    if (tx !== 1'b0) $display("FAIL tx_start_timeout: tx=%b, required 0", tx); else n_pass++;
    for (int i = 0; i < 720; i++) begin wave[i] = tx; @(negedge clk); end
    exp = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (wave[32 + 64*k] !== exp[k])
        $display("FAIL tx_bit%0d: got %b, required %b", k, wave[32 + 64*k], exp[k]);
      else n_pass++;
    end
    r = -1; f = -1;
    for (int i = 1; i < 720; i++) if (r < 0 && wave[i] === 1'b1) r = i;
    for (int i = 0; i < 720; i++) if (r >= 0 && i > r && f < 0 && wave[i] === 1'b0) f = i;
    n_checks++;
    if (f - r !== 64) $display("FAIL tx_bit_width: got %0d clocks, required 64", f - r); else n_pass++;
    lows = 0;
    for (int i = 9*64 + 32; i < 720; i++) if (wave[i] !== 1'b1) lows++;
    repeat (200) begin if (tx !== 1'b1) lows++; @(negedge clk); end
    n_checks++;
    if (lows !== 0) $display("FAIL tx_single_frame: %0d low samples after stop, required 0", lows); else n_pass++;
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    loop = 1'b1;
    bus_write(2'd0, 8'h3C, 1);
    repeat (800) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h08) $display("FAIL loop_status: got %h, required 08", d); else n_pass++;
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 8'h3C) $display("FAIL loop_data: got %h, required 3c", d); else n_pass++;
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 8'h00) $display("FAIL loop_empty_read: got %h, required 00", d); else n_pass++;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h09) $display("FAIL loop_status_after: got %h, required 09", d); else n_pass++;
    loop = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int t0, t;
    bus_write(2'd2, 8'h02, 1);
    // The first byte moves straight into the TX shifter, so 16 more fill the
    // FIFO and the 18th is the overflow.
    for (int i = 0; i < 18; i++) bus_write(2'd0, 8'(8'h40 + i), 1);
    t0 = cyc;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_busy: got %b, required 0", irq); else n_pass++;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h83) $display("FAIL ovf_status: got %h, required 83", d); else n_pass++;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h03) $display("FAIL ovf_clear: got %h, required 03", d); else n_pass++;
    t = 0;
    while (irq !== 1'b1 && t < 16000) begin @(negedge clk); t++; end
    n_checks++;
    if (irq !== 1'b1) $display("FAIL irq_timeout: irq=%b, required 1", irq); else n_pass++;
    n_checks++;
    if (cyc - t0 < 16*640)
      $display("FAIL irq_early: rose after %0d clocks, required >= %0d", cyc - t0, 16*640);
    else n_pass++;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h09 || tx !== 1'b1) $display("FAIL drain_status: got %h tx=%b, required 09 tx=1", d, tx); else n_pass++;
    bus_write(2'd2, 8'h00, 1);
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    send_rx(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h29) $display("FAIL frame_err_status: got %h, required 29", d); else n_pass++;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h09) $display("FAIL frame_err_clear: got %h, required 09", d); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (700) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h09) $display("FAIL glitch_status: got %h, required 09", d); else n_pass++;
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 8'h00) $display("FAIL glitch_data: got %h, required 00", d); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int t;
    bus_write(2'd0, 8'h00, 1);
    bus_write(2'd0, 8'hFF, 1);
    t = 0;
    while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) $display("FAIL pre_reset_tx: got %b, required 0", tx); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b, required 1", tx); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 8'h09) $display("FAIL post_reset_status: got %h, required 09", d); else n_pass++;
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 8'hA1) $display("FAIL post_reset_div: got %h, required a1", d); else n_pass++;
    repeat (400) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL post_reset_tx_idle: got %b, required 1", tx); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
